// File: rtl/rotor0_rev.sv
// rotor0_rev: return-path (reflector-to-keyboard) stage for rotor 0.
// Applies the inverse of Enigma rotor I wiring with a per-character
// position snapshot, in a two-stage valid/ready pipeline. The stage keeps
// its own copy of the rotor position, which stays in step with the forward
// rotor 0.
module rotor0_rev #(
    parameter logic [4:0] NOTCH = 5'd16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] data_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] data_out,
    output logic       out_err,
    input  logic       pos_load,
    input  logic [4:0] pos_value,
    input  logic       step,
    output logic [4:0] position,
    output logic       carry_out
);

    // Inverse wiring of rotor I: UWYGADFPVZBECKMTHXSLRINQOJ
    function automatic logic [4:0] winv(input logic [4:0] i);
        logic [4:0] r;
        case (i)
            5'd0:  r = 5'd20;  5'd1:  r = 5'd22;  5'd2:  r = 5'd24;
            5'd3:  r = 5'd6;   5'd4:  r = 5'd0;   5'd5:  r = 5'd3;
            5'd6:  r = 5'd5;   5'd7:  r = 5'd15;  5'd8:  r = 5'd21;
            5'd9:  r = 5'd25;  5'd10: r = 5'd1;   5'd11: r = 5'd4;
            5'd12: r = 5'd2;   5'd13: r = 5'd10;  5'd14: r = 5'd12;
            5'd15: r = 5'd19;  5'd16: r = 5'd7;   5'd17: r = 5'd23;
            5'd18: r = 5'd18;  5'd19: r = 5'd11;  5'd20: r = 5'd17;
            5'd21: r = 5'd8;   5'd22: r = 5'd13;  5'd23: r = 5'd16;
            5'd24: r = 5'd14;  5'd25: r = 5'd9;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic       adv;
    logic       accept;
    logic       s1_valid;
    logic [4:0] s1_idx;
    logic [4:0] s1_pos;
    logic       s1_err;

    logic [5:0] idx_sum;
    logic [4:0] idx;
    logic [5:0] w6;
    logic [5:0] p6;
    logic [5:0] diff;
    logic [4:0] load_val;
    logic       notch_step;

    // Handshake: S2 drains when empty or accepted; S1 refills if S2 moves or S1 is empty
    always_comb begin
        adv      = !out_valid || out_ready;
        in_ready = adv || !s1_valid;
        accept   = in_valid && in_ready;
    end

    // Datapath arithmetic: offset add, inverse lookup, offset subtract, load reduction
    always_comb begin
        idx_sum    = {1'b0, data_in} + {1'b0, position};
        idx        = (idx_sum >= 6'd26) ? 5'(idx_sum - 6'd26) : idx_sum[4:0];
        w6         = {1'b0, winv(s1_idx)};
        p6         = {1'b0, s1_pos};
        diff       = w6 + ((w6 < p6) ? 6'd26 : 6'd0) - p6;
        load_val   = (pos_value >= 5'd26) ? pos_value - 5'd26 : pos_value;
        notch_step = step && !pos_load && (position == NOTCH);
    end

    // Stage S1: capture offset index, position snapshot and illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_pos   <= '0;
            s1_err   <= 1'b0;
        end else if (adv || !s1_valid) begin
            s1_valid <= accept;
            if (accept) begin
                s1_idx <= idx;
                s1_pos <= position;
                s1_err <= (data_in >= 5'd26);
            end
        end
    end

    // Stage S2: inverse lookup result, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            out_err   <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_err  <= s1_err;
                data_out <= s1_err ? 5'd31 : diff[4:0];
            end
        end
    end

    // Position register (load beats step) and registered notch carry pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            position  <= '0;
            carry_out <= 1'b0;
        end else begin
            carry_out <= notch_step;
            if (pos_load) begin
                position <= load_val;
            end else if (step) begin
                position <= (position == 5'd25) ? 5'd0 : position + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_rotor0_rev.sv
// Directed self-checking bench for rotor0_rev with a small output scoreboard.
module tb_rotor0_rev;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] data_in;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] data_out;
    logic       out_err;
    logic       pos_load;
    logic [4:0] pos_value;
    logic       step;
    logic [4:0] position;
    logic       carry_out;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_out    = 0;

    logic [5:0] exp_q[$];
    logic [5:0] exp_cur;

    int fwd_t[26] = '{4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9};

    rotor0_rev #(.NOTCH(5'd16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_err   (out_err),
        .pos_load  (pos_load),
        .pos_value (pos_value),
        .step      (step),
        .position  (position),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Forward rotor I model: (F[(l+p) mod 26] - p) mod 26
    function automatic logic [4:0] fwd_map(input int p, input int l);
        int i;
        i = (l + p) % 26;
        return 5'((fwd_t[i] - p + 26) % 26);
    endfunction

    // One clock: observe at negedge (scoreboard + accept tracking), then step past posedge
    task automatic cycle();
        @(negedge clk);
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
            else check("data", {out_err, data_out}, exp_q.pop_front());
        end
        if (in_valid && in_ready) exp_q.push_back(exp_cur);
        @(posedge clk);
        #1;
    endtask

    task automatic load_pos(input logic [4:0] v);
        pos_load  = 1'b1;
        pos_value = v;
        cycle();
        pos_load  = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Send one character, measure edges until out_valid, then let it be consumed
    task automatic send_one(input logic [4:0] d, input logic [5:0] e);
        int lat;
        data_in  = d;
        exp_cur  = e;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            cycle();
            lat++;
        end
        check("latency", lat, 2);
        drain(2);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b1;
        pos_load = 1'b0; pos_value = '0; step = 1'b0; exp_cur = '0;

        // Reset state
        #12;
        check("rst_position", position, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_out_err", out_err, 0);
        check("rst_carry", carry_out, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        // Basic inverse
        send_one(5'd4, 6'd0);
        load_pos(5'd1);
        check("pos_after_load1", position, 1);
        send_one(5'd0, 6'd21);
        check("fwd_model_p1_in21", fwd_map(1, 21), 0);

        // Exhaustive round trip, streaming
        for (int p = 0; p < 26; p++) begin
            load_pos(5'(p));
            in_valid = 1'b1;
            for (int l = 0; l < 26; l++) begin
                data_in = fwd_map(p, l);
                exp_cur = 6'(l);
                cycle();
            end
            in_valid = 1'b0;
            drain(3);
        end
        check("roundtrip_drained", exp_q.size(), 0);

        // Stepping and notch
        load_pos(5'd16);
        check("load16", position, 16);
        step = 1'b1; cycle(); step = 1'b0;
        check("step_from_16", position, 17);
        check("carry_pulse", carry_out, 1);
        cycle();
        check("carry_one_cycle", carry_out, 0);
        load_pos(5'd25);
        step = 1'b1; cycle(); step = 1'b0;
        check("wrap_25", position, 0);
        check("wrap_no_carry", carry_out, 0);
        pos_load = 1'b1; pos_value = 5'd16; step = 1'b1; cycle();
        pos_load = 1'b0; step = 1'b0;
        check("load_wins", position, 16);
        check("load_step_no_carry", carry_out, 0);
        step = 1'b1; cycle(); step = 1'b0;
        check("b2b_carry_a", carry_out, 1);
        pos_load = 1'b1; pos_value = 5'd16; step = 1'b1; cycle();
        pos_load = 1'b0;
        check("b2b_reload_no_carry", carry_out, 0);
        cycle(); step = 1'b0;
        check("b2b_carry_b", carry_out, 1);
        load_pos(5'd30);
        check("load_mod26", position, 4);

        // Snapshot ordering: accept and step on the same edge
        load_pos(5'd0);
        data_in = 5'd0; exp_cur = 6'd20; in_valid = 1'b1; step = 1'b1;
        cycle();
        in_valid = 1'b0; step = 1'b0;
        check("snap_pos_advanced", position, 1);
        drain(3);
        check("snap_drained", exp_q.size(), 0);

        // Backpressure
        load_pos(5'd0);
        n_out = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        data_in = 5'd4; exp_cur = 6'd0;  cycle();
        data_in = 5'd0; exp_cur = 6'd20; cycle();
        data_in = 5'd1; exp_cur = 6'd22;
        cycle();
        check("bp_in_ready_low", in_ready, 0);
        check("bp_queued", exp_q.size(), 2);
        check("bp_hold_data", data_out, 0);
        cycle();
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data2", data_out, 0);
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        drain(4);
        check("bp_out_count", n_out, 3);
        check("bp_drained", exp_q.size(), 0);

        // Illegal input
        load_pos(5'd5);
        send_one(5'd27, {1'b1, 5'd31});
        check("illegal_pos_kept", position, 5);

        // Reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1;
        data_in = 5'd3; exp_cur = 6'd0; cycle();
        data_in = 5'd7; cycle();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_position", position, 0);
        check("mid_rst_data_out", data_out, 0);
        check("mid_rst_in_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("no_stale_valid", out_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
